aes_state_loader: RTL and testbench

- Upstream input stage of the AES datapath. It assembles four 32-bit words from the host bus into one 128-bit state block.
- It presents the block with a valid/ready handshake to the AES round core and to the state-monitoring logic, which share the `state` bus.
- One block is held stable on `state` until it is consumed. A second block is assembled in parallel, so the host is not stalled while output is pending.

---
 rtl/aes_state_loader_pkg.sv | 16 +
 rtl/aes_state_loader_state_out_reg.sv | 51 +++++
 rtl/aes_state_loader.sv | 79 +++++++
 tb/tb_aes_state_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_state_loader_pkg.sv
// Shared AES datapath constants, the 128-bit state type and the word-slot offset helper.
// No logic; imported by the state loader and its output stage.
package aes_state_loader_pkg;

    localparam int AES_WORD_W    = 32;
    localparam int AES_NUM_WORDS = 4;
    localparam int AES_STATE_W   = AES_WORD_W * AES_NUM_WORDS;

    typedef logic [AES_STATE_W-1:0] state_t;

    // Big-endian packing: slot 0 is the most significant word of the block.
    function automatic int word_slot(input logic [1:0] idx);
        return AES_STATE_W - AES_WORD_W * (int'(idx) + 1);
    endfunction

endpackage

// File: rtl/aes_state_loader_state_out_reg.sv
// Output register holding one assembled block behind a valid/ready handshake, plus the consumed-block counter.
// Latency: a load offered at edge k appears on o_state after edge k; o_load_rdy is combinational.
// Backpressure: while o_out_vld=1 and i_out_rdy=0 the register holds and o_load_rdy stays low.
module aes_state_loader_state_out_reg
    import aes_state_loader_pkg::*;
#(
    parameter int STATE_W = AES_STATE_W,
    parameter int CNT_W   = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load_vld,
    input  logic [STATE_W-1:0] i_load_dat,
    output logic               o_load_rdy,
    output logic [STATE_W-1:0] o_state,
    output logic               o_out_vld,
    input  logic               i_out_rdy,
    output logic [CNT_W-1:0]   o_block_count
);

    logic [STATE_W-1:0] r_state;
    logic               r_out_vld;
    logic [CNT_W-1:0]   r_block_count;
    logic               w_consume;

    assign w_consume     = r_out_vld && i_out_rdy;
    assign o_load_rdy    = !r_out_vld || i_out_rdy;
    assign o_state       = r_state;
    assign o_out_vld     = r_out_vld;
    assign o_block_count = r_block_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= '0;
            r_out_vld     <= 1'b0;
            r_block_count <= '0;
        end else begin
            if (w_consume) begin
                r_block_count <= r_block_count + 1'b1;
            end
            // A new block replaces one being consumed in the same cycle, so the handshake never bubbles.
            if (i_load_vld && o_load_rdy) begin
                r_state   <= i_load_dat;
                r_out_vld <= 1'b1;
            end else if (w_consume) begin
                r_out_vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/aes_state_loader.sv
// Assembles NUM_WORDS host words (big-endian) into one AES state block and hands it to the output register.
// Latency: block appears on state one edge after its last word is accepted, if the output register is free.
// Backpressure: in_ready drops while a completed block waits; host assembles the next block during output stalls.
module aes_state_loader
    import aes_state_loader_pkg::*;
#(
    parameter int WORD_W    = AES_WORD_W,
    parameter int NUM_WORDS = AES_NUM_WORDS,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WORD_W-1:0]           in_word,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        flush,
    output logic [WORD_W*NUM_WORDS-1:0] state,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CNT_W-1:0]            block_count,
    output logic [1:0]                  word_idx
);

    localparam int         STATE_W  = WORD_W * NUM_WORDS;
    localparam logic [1:0] LAST_IDX = 2'(NUM_WORDS - 1);

    logic [STATE_W-1:0] r_asm_reg;
    logic [1:0]         r_cnt;
    logic               r_asm_full;
    logic               w_accept;
    logic               w_load_rdy;
    logic               w_move;

    assign in_ready = !r_asm_full;
    assign w_accept = in_valid && !r_asm_full && !flush;
    assign w_move   = r_asm_full && w_load_rdy;
    assign word_idx = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_asm_reg  <= '0;
            r_cnt      <= '0;
            r_asm_full <= 1'b0;
        end else begin
            if (w_accept) begin
                r_asm_reg[word_slot(r_cnt) +: WORD_W] <= in_word;
                if (r_cnt == LAST_IDX) begin
                    r_cnt      <= '0;
                    r_asm_full <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 2'd1;
                end
            end
            // A block complete at cycle start still moves out under flush; only its full flag is dropped here.
            if (w_move || flush) begin
                r_asm_full <= 1'b0;
            end
            if (flush) begin
                r_cnt <= '0;
            end
        end
    end

    aes_state_loader_state_out_reg #(
        .STATE_W (STATE_W),
        .CNT_W   (CNT_W)
    ) u_state_out_reg (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_load_vld    (r_asm_full),
        .i_load_dat    (r_asm_reg),
        .o_load_rdy    (w_load_rdy),
        .o_state       (state),
        .o_out_vld     (out_valid),
        .i_out_rdy     (out_ready),
        .o_block_count (block_count)
    );

endmodule

// File: tb/tb_aes_state_loader.sv
// Directed bench for aes_state_loader: cycle model with per-cycle compare plus literal checkpoints.
// A second instance with a 3-bit counter shares all inputs so counter wrap is reached in a few blocks.
module tb_aes_state_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  in_word;
    logic         in_valid;
    logic         flush;
    logic         out_ready;

    logic         in_ready;
    logic [127:0] state;
    logic         out_valid;
    logic [15:0]  block_count;
    logic [1:0]   word_idx;

    logic         n_in_ready;
    logic [127:0] n_state;
    logic         n_out_valid;
    logic [2:0]   n_block_count;
    logic [1:0]   n_word_idx;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    aes_state_loader dut (
        .clk         (clk),
        .rst         (rst),
        .in_word     (in_word),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .state       (state),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .block_count (block_count),
        .word_idx    (word_idx)
    );

    aes_state_loader #(.CNT_W(3)) dut_narrow (
        .clk         (clk),
        .rst         (rst),
        .in_word     (in_word),
        .in_valid    (in_valid),
        .in_ready    (n_in_ready),
        .flush       (flush),
        .state       (n_state),
        .out_valid   (n_out_valid),
        .out_ready   (out_ready),
        .block_count (n_block_count),
        .word_idx    (n_word_idx)
    );

    // Behavioural model: words kept as an array, packed big-endian only when the block moves out.
    logic [31:0]  m_words [4];
    logic [1:0]   m_cnt;
    bit           m_full;
    logic [127:0] m_state;
    bit           m_vld;
    logic [15:0]  m_count;

    always @(posedge clk) begin
        bit old_full, old_vld, acc, move;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_words[i] = 32'h0;
            m_cnt = 2'd0; m_full = 1'b0; m_state = '0; m_vld = 1'b0; m_count = 16'd0;
        end else begin
            old_full = m_full;
            old_vld  = m_vld;
            acc  = in_valid && !old_full && !flush;
            move = old_full && (!old_vld || out_ready);
            if (old_vld && out_ready) m_count = m_count + 16'd1;
            if (move) begin
                m_state = {m_words[0], m_words[1], m_words[2], m_words[3]};
                m_vld   = 1'b1;
                m_full  = 1'b0;
            end else if (old_vld && out_ready) begin
                m_vld = 1'b0;
            end
            if (flush) begin
                m_cnt  = 2'd0;
                m_full = 1'b0;
            end
            if (acc) begin
                m_words[m_cnt] = in_word;
                if (m_cnt == 2'd3) begin
                    m_cnt  = 2'd0;
                    m_full = 1'b1;
                end else begin
                    m_cnt = m_cnt + 2'd1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc in_ready",    128'(in_ready),      128'(!m_full));
            check("cyc out_valid",   128'(out_valid),     128'(m_vld));
            check("cyc state",       state,               m_state);
            check("cyc block_count", 128'(block_count),   128'(m_count));
            check("cyc word_idx",    128'(word_idx),      128'(m_cnt));
            check("cyc narrow cnt",  128'(n_block_count), 128'(m_count[2:0]));
            check("cyc narrow vld",  128'(n_out_valid),   128'(m_vld));
        end
    end

    task automatic send_word(input logic [31:0] w);
        bit rdy;
        bit done = 1'b0;
        in_word  = w;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                done = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_word timeout: word %h never accepted", w);
        end
    endtask

    task automatic send_block(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3);
        send_word(w0);
        send_word(w1);
        send_word(w2);
        send_word(w3);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_word = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        check("reset state",       state,               128'h0);
        check("reset out_valid",   128'(out_valid),     128'h0);
        check("reset block_count", 128'(block_count),   128'h0);
        check("reset word_idx",    128'(word_idx),      128'h0);
        check("reset in_ready",    128'(in_ready),      128'h1);

        // Basic assembly and consumption
        out_ready = 1'b1;
        send_block(32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff);
        step();
        check("t1 state",     state, 128'h00112233_44556677_8899aabb_ccddeeff);
        check("t1 out_valid", 128'(out_valid), 128'h1);
        step();
        check("t1 block_count", 128'(block_count), 128'd1);
        check("t1 consumed",    128'(out_valid),   128'h0);

        // Output stalled: A held, B assembled behind it
        out_ready = 1'b0;
        send_block(32'h1, 32'h1, 32'h1, 32'h1);
        send_block(32'h2, 32'h2, 32'h2, 32'h2);
        check("t2 in_ready low", 128'(in_ready), 128'h0);
        repeat (3) step();
        check("t2 state held A", state, {4{32'h1}});
        check("t2 still blocked", 128'(in_ready), 128'h0);
        out_ready = 1'b1;
        step();
        check("t2 state B",       state, {4{32'h2}});
        check("t2 block_count 2", 128'(block_count), 128'd2);
        step();
        check("t2 block_count 3", 128'(block_count), 128'd3);

        // Flush of a partial block
        send_word(32'h55);
        send_word(32'h66);
        check("t3 word_idx 2", 128'(word_idx), 128'd2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t3 word_idx flushed", 128'(word_idx), 128'd0);
        send_block(32'hA, 32'hB, 32'hC, 32'hD);
        step();
        check("t3 state", state, 128'h0000000A_0000000B_0000000C_0000000D);
        step();

        // Flush together with a valid word drops it
        send_word(32'h77);
        flush = 1'b1; in_valid = 1'b1; in_word = 32'h99;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("t4 word_idx", 128'(word_idx), 128'd0);
        check("t4 in_ready", 128'(in_ready), 128'h1);

        // Complete block still moves out under flush when the output is free
        send_block(32'h10, 32'h11, 32'h12, 32'h13);
        flush = 1'b1; out_ready = 1'b0;
        step();
        flush = 1'b0;
        check("t4 moved under flush", state, 128'h00000010_00000011_00000012_00000013);
        check("t4 out_valid",         128'(out_valid), 128'h1);

        // Complete block discarded by flush when the output is blocked
        send_block(32'h20, 32'h21, 32'h22, 32'h23);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t4 discard in_ready", 128'(in_ready), 128'h1);
        out_ready = 1'b1;
        step();
        check("t4 state retained", state, 128'h00000010_00000011_00000012_00000013);
        check("t4 drained",        128'(out_valid), 128'h0);

        // Reset with a pending output block and a partial block
        out_ready = 1'b0;
        send_block(32'h30, 32'h31, 32'h32, 32'h33);
        step();
        send_word(32'h40);
        send_word(32'h41);
        check("t5 pre-reset valid", 128'(out_valid), 128'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5 out_valid",   128'(out_valid),   128'h0);
        check("t5 state",       state,             128'h0);
        check("t5 block_count", 128'(block_count), 128'h0);
        check("t5 word_idx",    128'(word_idx),    128'h0);
        check("t5 in_ready",    128'(in_ready),    128'h1);

        // Counter wrap, observed on the 3-bit instance
        out_ready = 1'b1;
        for (int b = 0; b < 7; b++) begin
            send_block(32'(b), 32'(b + 1), 32'(b + 2), 32'(b + 3));
        end
        repeat (2) step();
        check("t6 narrow 7",  128'(n_block_count), 128'd7);
        send_block(32'hF0, 32'hF1, 32'hF2, 32'hF3);
        repeat (2) step();
        check("t6 narrow wrap", 128'(n_block_count), 128'd0);
        check("t6 wide 8",      128'(block_count),   128'd8);

        repeat (2) step();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
